// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU opcodes, ALUOp encodings and control FSM state/strobe types
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_SUBI  = 4'b0010;
    localparam logic [3:0] OP_SLTI  = 4'b0011;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_ALU,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       ir_write;
    } ctrl_t;

endpackage

// File: rtl/control_fsm_if.sv
// rtl/control_fsm_if.sv - opcode/stall inputs and datapath control strobes between control_fsm and datapath
interface control_fsm_if #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 2
);
    logic [OPW-1:0]    opcode;
    logic              Stall;
    logic              RegDst;
    logic              Branch;
    logic              MemRead;
    logic              MemWrite;
    logic              RegWrite;
    logic              MemToReg;
    logic              ALUSrc;
    logic [ALUOPW-1:0] ALUOp;
    logic              PCWrite;
    logic              IRWrite;
    logic              Halted;
    logic              Illegal;

    modport master (
        input  opcode, Stall,
        output RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
               ALUOp, PCWrite, IRWrite, Halted, Illegal
    );

    modport slave (
        output opcode, Stall,
        input  RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
               ALUOp, PCWrite, IRWrite, Halted, Illegal
    );
endinterface

// File: rtl/control_fsm_outdec.sv
// rtl/control_fsm_outdec.sv - combinational state-to-strobe decoder with stall gating of write strobes
module control_fsm_outdec
    import cpu_pkg::*;
(
    input  state_t state,
    input  logic   rtype,
    input  logic   stall,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_op = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALUOP_IMM;
            end
            S_WB_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = rtype;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
            end
            S_WB_MEM: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            default: ;
        endcase

        // A stalled cycle must not commit anything; read/select strobes stay so the datapath keeps its operands.
        if (stall) begin
            ctrl.pc_write  = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.branch    = 1'b0;
        end
    end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle CPU control FSM; CONTROL_FSM_PERF_CNT_EN adds cycle_cnt/instr_cnt
module control_fsm
    import cpu_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int ALUOPW = 2
) (
    input  logic              Clock,
    input  logic              Reset_n,
    control_fsm_if.master     bus
`ifdef CONTROL_FSM_PERF_CNT_EN
    ,
    output logic [15:0]       cycle_cnt,
    output logic [15:0]       instr_cnt
`endif
);

    state_t           state;
    logic             rtype_q;
    logic             store_q;
    logic             illegal_q;
    logic             halted_q;
    logic [OPW-1:0]   op;
    ctrl_t            ctrl;

    assign op = bus.opcode;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            rtype_q   <= 1'b0;
            store_q   <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else if (!bus.Stall) begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OPW'(OP_RTYPE): begin
                            state   <= S_EXEC_R;
                            rtype_q <= 1'b1;
                        end
                        OPW'(OP_ADDI), OPW'(OP_SUBI), OPW'(OP_SLTI): begin
                            state   <= S_EXEC_I;
                            rtype_q <= 1'b0;
                        end
                        OPW'(OP_LW): begin
                            state   <= S_MEM_ADDR;
                            store_q <= 1'b0;
                        end
                        OPW'(OP_SW): begin
                            state   <= S_MEM_ADDR;
                            store_q <= 1'b1;
                        end
                        OPW'(OP_BEQ):  state <= S_BRANCH;
                        OPW'(OP_HALT): begin
                            state    <= S_HALT;
                            halted_q <= 1'b1;
                        end
                        default: begin
                            state     <= S_FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state <= S_WB_ALU;
                // LW/SW decision was captured at DECODE, the opcode input may already have moved on.
                S_MEM_ADDR: state <= store_q ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   state <= S_WB_MEM;
                S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH: state <= S_FETCH;
                S_HALT:     state <= S_HALT;
                default:    state <= S_IDLE;
            endcase
        end
    end

    control_fsm_outdec u_outdec (
        .state (state),
        .rtype (rtype_q),
        .stall (bus.Stall),
        .ctrl  (ctrl)
    );

    assign bus.RegDst   = ctrl.reg_dst;
    assign bus.Branch   = ctrl.branch;
    assign bus.MemRead  = ctrl.mem_read;
    assign bus.MemWrite = ctrl.mem_write;
    assign bus.RegWrite = ctrl.reg_write;
    assign bus.MemToReg = ctrl.mem_to_reg;
    assign bus.ALUSrc   = ctrl.alu_src;
    assign bus.ALUOp    = ALUOPW'(ctrl.alu_op);
    assign bus.PCWrite  = ctrl.pc_write;
    assign bus.IRWrite  = ctrl.ir_write;
    assign bus.Halted   = halted_q;
    assign bus.Illegal  = illegal_q;

`ifdef CONTROL_FSM_PERF_CNT_EN
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            cycle_cnt <= 16'd0;
            instr_cnt <= 16'd0;
        end else if (!bus.Stall) begin
            if (state != S_IDLE && state != S_HALT) begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
            if (state == S_WB_ALU || state == S_WB_MEM || state == S_MEM_WR || state == S_BRANCH) begin
                instr_cnt <= instr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
